// File: rtl/traffic_display_scan.sv
// Four-digit multiplexed seven-segment driver for the traffic light controller; optional yellow blink via TRAFFIC_DISPLAY_BLINK_EN.
// Latency: inputs snapshotted at each idx-0 tick, shown BLANK_CYC cycles later; worst case 4*SCAN_DIV+BLANK_CYC.
// Backpressure: none; lights/counter are level inputs sampled only at frame snapshot edges.
module traffic_display_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 2,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [5:0] lights,
    input  logic [3:0] counter,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] BLANK_V = PRE_W'(BLANK_CYC);

    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_Y     = 7'b0010001;
    localparam logic [6:0] SEG_G     = 7'b1000010;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    generate
        if (SCAN_DIV < BLANK_CYC + 2) begin : g_bad_scan_div
            $error("SCAN_DIV must be at least BLANK_CYC+2");
        end
        if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
            $error("BLINK_FRAMES must be at least 1");
        end
    endgenerate

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Anything other than exactly one lamp per road is shown as a dash.
    function automatic logic [6:0] seg_letter(input logic [2:0] grp, input logic show_yel);
        logic [6:0] s;
        case (grp)
            3'b100:  s = SEG_R;
            3'b010:  s = show_yel ? SEG_Y : SEG_BLANK;
            3'b001:  s = SEG_G;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [1:0]       idx_q, idx_d;
    logic             started_q, started_d;
    logic [5:0]       snap_l_q, snap_l_d;
    logic [3:0]       snap_c_q, snap_c_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             tick;
    logic             snap_tick;
    logic             yel_on;

    assign tick      = (pre_q == PRE_MAX);
    assign snap_tick = tick && ((idx_q == 2'd3) || !started_q);

`ifdef TRAFFIC_DISPLAY_BLINK_EN
    localparam int FR_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [FR_W-1:0] FR_MAX = FR_W'(BLINK_FRAMES - 1);

    logic [FR_W-1:0] fcnt_q, fcnt_d;
    logic            phase_on_q, phase_on_d;

    // The first snapshot after reset starts frame 1 and is not counted, so every phase lasts exactly BLINK_FRAMES frames.
    always_comb begin
        fcnt_d     = fcnt_q;
        phase_on_d = phase_on_q;
        if (snap_tick && started_q) begin
            if (fcnt_q == FR_MAX) begin
                fcnt_d     = '0;
                phase_on_d = !phase_on_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            fcnt_q     <= '0;
            phase_on_q <= 1'b1;
        end else begin
            fcnt_q     <= fcnt_d;
            phase_on_q <= phase_on_d;
        end
    end

    assign yel_on = phase_on_d;
`else
    assign yel_on = 1'b1;
`endif

    always_comb begin
        pre_d     = tick ? '0 : pre_q + 1'b1;
        idx_d     = idx_q;
        started_d = started_q;
        snap_l_d  = snap_l_q;
        snap_c_d  = snap_c_q;
        seg_d     = seg_q;

        if (snap_tick) begin
            snap_l_d  = lights;
            snap_c_d  = counter;
            idx_d     = 2'd0;
            started_d = 1'b1;
        end else if (tick) begin
            idx_d = idx_q + 2'd1;
        end

        // Segments change only at slot ticks, while the anodes are blanked.
        if (tick) begin
            case (idx_d)
                2'd0:    seg_d = seg_digit((snap_c_d >= 4'd10) ? snap_c_d - 4'd10 : snap_c_d);
                2'd1:    seg_d = (snap_c_d >= 4'd10) ? seg_digit(4'd1) : SEG_BLANK;
                2'd2:    seg_d = seg_letter(snap_l_d[2:0], yel_on);
                default: seg_d = seg_letter(snap_l_d[5:3], yel_on);
            endcase
        end

        if ((pre_d < BLANK_V) || !started_d) begin
            an_d = 4'b1111;
        end else begin
            an_d = ~(4'b0001 << idx_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            pre_q     <= '0;
            idx_q     <= 2'd0;
            started_q <= 1'b0;
            snap_l_q  <= 6'd0;
            snap_c_q  <= 4'd0;
            an_q      <= 4'b1111;
            seg_q     <= SEG_BLANK;
        end else begin
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            started_q <= started_d;
            snap_l_q  <= snap_l_d;
            snap_c_q  <= snap_c_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_traffic_display_scan.sv
// Directed bench for traffic_display_scan with SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2.
module tb_traffic_display_scan;

    logic       clk = 1'b0;
    logic       clr;
    logic [5:0] lights;
    logic [3:0] counter;
    logic [3:0] an;
    logic [6:0] seg;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [6:0] S_0     = 7'b1000000;
    localparam logic [6:0] S_1     = 7'b1111001;
    localparam logic [6:0] S_3     = 7'b0110000;
    localparam logic [6:0] S_5     = 7'b0010010;
    localparam logic [6:0] S_8     = 7'b0000000;
    localparam logic [6:0] S_R     = 7'b0101111;
    localparam logic [6:0] S_Y     = 7'b0010001;
    localparam logic [6:0] S_G     = 7'b1000010;
    localparam logic [6:0] S_DASH  = 7'b0111111;
    localparam logic [6:0] S_BLANK = 7'b1111111;
`ifdef TRAFFIC_DISPLAY_BLINK_EN
    localparam logic [6:0] S_Y_F4  = S_BLANK;
`else
    localparam logic [6:0] S_Y_F4  = S_Y;
`endif

    traffic_display_scan #(
        .SCAN_DIV    (8),
        .BLANK_CYC   (2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk    (clk),
        .clr    (clr),
        .lights (lights),
        .counter(counter),
        .an     (an),
        .seg    (seg)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Entered 1 time unit after a slot tick; returns 1 time unit after the following tick.
    task automatic check_slot(input string tag, input int idx, input logic [6:0] exp_seg);
        logic [3:0] on_an;
        on_an = ~(4'b0001 << idx);
        check_val({tag, "_seg"}, {1'b0, seg}, {1'b0, exp_seg});
        check_val({tag, "_an_blank"}, {4'b0, an}, 8'h0f);
        step(2);
        check_val({tag, "_an_on"}, {4'b0, an}, {4'b0, on_an});
        step(5);
        check_val({tag, "_an_end"}, {4'b0, an}, {4'b0, on_an});
        check_val({tag, "_seg_end"}, {1'b0, seg}, {1'b0, exp_seg});
        step(1);
    endtask

    initial begin
        clr     = 1'b0;
        lights  = 6'b100001;
        counter = 4'd8;
        step(3);
        check_val("rst_an", {4'b0, an}, 8'h0f);
        check_val("rst_seg", {1'b0, seg}, {1'b0, S_BLANK});
        clr = 1'b1;

        step(7);
        check_val("pre_tick_an", {4'b0, an}, 8'h0f);
        check_val("pre_tick_seg", {1'b0, seg}, {1'b0, S_BLANK});
        step(1);
        check_val("tick8_an", {4'b0, an}, 8'h0f);
        step(1);
        check_val("edge9_an", {4'b0, an}, 8'h0f);
        step(1);
        check_val("edge10_an", {4'b0, an}, 8'h0e);
        step(6);

        // Frame 1: counter 8, A red, B green; counter moves to 3 mid-frame.
        check_slot("f1_d1", 1, S_BLANK);
        counter = 4'd3;
        check_slot("f1_d2", 2, S_G);
        check_slot("f1_d3", 3, S_R);

        // Frame 2 picks up the new count; live inputs changed here must not leak in.
        check_slot("f2_d0", 0, S_3);
        counter = 4'd15;
        lights  = 6'b001100;
        check_slot("f2_d1", 1, S_BLANK);
        check_slot("f2_d2", 2, S_G);
        check_slot("f2_d3", 3, S_R);

        check_slot("f3_d0", 0, S_5);
        lights  = 6'b110010;
        counter = 4'd0;
        check_slot("f3_d1", 1, S_1);
        check_slot("f3_d2", 2, S_R);
        check_slot("f3_d3", 3, S_G);

        check_slot("f4_d0", 0, S_0);
        check_slot("f4_d1", 1, S_BLANK);
        check_slot("f4_d2", 2, S_Y_F4);
        check_slot("f4_d3", 3, S_DASH);

        // Reset in the middle of the idx2 slot.
        check_slot("f5_d0", 0, S_0);
        check_slot("f5_d1", 1, S_BLANK);
        step(3);
        clr = 1'b0;
        step(1);
        check_val("mid_rst_an", {4'b0, an}, 8'h0f);
        check_val("mid_rst_seg", {1'b0, seg}, {1'b0, S_BLANK});
        clr = 1'b1;
        step(7);
        check_val("restart_pre_an", {4'b0, an}, 8'h0f);
        check_val("restart_pre_seg", {1'b0, seg}, {1'b0, S_BLANK});
        step(1);
        check_slot("r_d0", 0, S_0);
        check_slot("r_d1", 1, S_BLANK);
        check_slot("r_d2", 2, S_Y);
        check_slot("r_d3", 3, S_DASH);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/traffic_display_scan.md
Name: traffic_display_scan

Overview:
- Downstream consumer of the two-road traffic light controller.
- Takes the controller's `lights[5:0]` phase vector and `counter[3:0]` countdown and drives a 4-digit, time-multiplexed, common-anode seven-segment display.
- Digits: countdown ones, countdown tens, road B phase letter, road A phase letter.
- Inputs are snapshotted once per scan frame so a refresh never shows a mix of two controller states.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot; must be >= BLANK_CYC+2.
- BLANK_CYC, 2, cycles at the start of each slot with all anodes off (anti-ghosting); must be < SCAN_DIV.
- BLINK_FRAMES, 125, scan frames per blink half-period; used only when the blink feature is compiled in.

Ports:
- clk  input  1  system clock
- clr  input  1  synchronous, active-low reset
- lights  input  6  [5:3] road A {R,Y,G}, [2:0] road B {R,Y,G}, one-hot per road
- counter  input  4  remaining seconds, 0..15
- an  output  4  digit enables, active-low, an[i] selects digit i
- seg  output  7  {g,f,e,d,c,b,a}, active-low

Behaviour:
- One clock (clk). Reset is synchronous and active-low (clr).
- All state and outputs are registered.
- Reset (clr=0 at a clk edge), regardless of current slot:
  - Prescaler pre=0, index idx=0, started=0.
  - Snapshot snap_l=0, snap_c=0; blink phase=on.
  - an=4'b1111, seg=7'b1111111.
- Prescaler: pre counts 0..SCAN_DIV-1 and wraps. The edge where pre==SCAN_DIV-1 is the slot tick.
- At a slot tick:
  - If idx==3 or started==0: snap_l<=lights, snap_c<=counter, idx<=0, started<=1.
  - Otherwise: idx<=idx+1.
  - seg is loaded on the same edge from the new idx. For idx 0 it uses the values being loaded into the snapshot (the inputs at that edge).
- Anodes:
  - an=4'b1111 while (post-edge) pre<BLANK_CYC or started==0.
  - Otherwise an has only bit idx low.
  - So a digit turns on BLANK_CYC cycles after its tick.
- Digit content (from the snapshot only):
  - idx0: snap_c mod 10.
  - idx1: snap_c/10, which is '1' for 10..15; blank for 0..9 (leading-zero blanking).
  - idx2: letter for snap_l[2:0].
  - idx3: letter for snap_l[5:3].
- Letter map: 100='r', 010='y', 001='G'; any non-one-hot group (000, 110, 111, ...) = '-'.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - r=0101111, y=0010001, G=1000010, '-'=0111111, blank=1111111
- Input changes between frame snapshots have no effect on outputs until the next idx-0 tick.
- Frame length: 4*SCAN_DIV cycles. Worst-case input-to-display latency: 4*SCAN_DIV + BLANK_CYC cycles.
- No handshake: inputs are level signals sampled only at snapshot edges.

Optional Feature:
- Macro: TRAFFIC_DISPLAY_BLINK_EN
- Defined:
  - A frame counter toggles the blink phase every BLINK_FRAMES frames, counted at idx-0 snapshot ticks.
  - While phase=off, any letter digit whose snapshot group is 010 (yellow) shows blank. Its anode still asserts.
  - Phase resets to on.
  - Count and phase digits are unaffected.
- Undefined:
  - No blink counter is present.
  - The yellow letter displays steadily.

Test Plan (SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2):
- Reset:
  - Stimulus: hold clr=0 for 3 cycles, then release.
  - Required: an=1111 and seg=1111111 through the first tick at edge 8 after release. an=1110 from edge 10.
- Frame contents:
  - Stimulus: lights=100001, counter=8.
  - Required, one slot each:
    - idx0: seg 0000000 ('8').
    - idx1: blank.
    - idx2: 1000010 ('G').
    - idx3: 0101111 ('r').
  - Each digit's anode is low only for slot cycles 2..7.
- Tens digit:
  - Stimulus: counter=15, lights=001100.
  - Required: idx0 0010010 ('5'), idx1 1111001 ('1'), idx2 'r', idx3 'G'.
- Snapshot coherence:
  - Stimulus: change counter 8->3 during the idx1 slot.
  - Required: idx0 keeps '8' until the next frame's idx0 tick, then shows 0110000.
- Invalid phase vector:
  - Stimulus: lights=110010.
  - Required: idx3 '-' (0111111), idx2 'y' (0010001).
- Reset mid-frame:
  - Stimulus: clr=0 for 1 cycle during the idx2 slot.
  - Required: next edge an=1111, seg blank. Display restarts at idx0 after 8 cycles. With TRAFFIC_DISPLAY_BLINK_EN defined, the yellow letter is blank in alternate 2-frame periods.
